// File: rtl/sum_nb_seq_if.sv
// Operand/result bundle for the sequential adder/subtractor.
// The master side supplies the request and operands; the slave side returns the status and result.
interface sum_nb_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] xi;
    logic [WIDTH-1:0] yi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] zi;
    logic             co;
    logic             ov;

    modport master (
        output start, sub, xi, yi,
        input  busy, done, zi, co, ov
    );

    modport slave (
        input  start, sub, xi, yi,
        output busy, done, zi, co, ov
    );
endinterface

// File: rtl/sum_nb_seq.sv
// Digit-serial adder/subtractor: works through DIGIT bits per clock, LSB first,
// and publishes the sum, carry and signed overflow together with a one-cycle done pulse.
module sum_nb_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    sum_nb_seq_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] zi_reg;
    logic             carry;
    logic             co_reg;
    logic             ov_reg;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   digit_sum;
    logic             take;
    logic             last_step;
    logic             msb_cin;

    always_comb begin
        take      = bus.start && ((state == IDLE) || (state == DONE));
        last_step = (state == RUN) && (cnt == CW'(STEPS - 1));
        digit_sum = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        // On the final step this digit holds the MSB, so a^b^s recovers the carry into it.
        msb_cin   = a_reg[DIGIT-1] ^ b_reg[DIGIT-1] ^ digit_sum[DIGIT-1];
    end

    // New digits enter the sum register from the top so the LSB digit lands at bit 0 after all steps.
    if (WIDTH > DIGIT) begin : g_shift
        assign sum_next = {digit_sum[DIGIT-1:0], sum_reg[WIDTH-1:DIGIT]};
    end else begin : g_whole
        assign sum_next = digit_sum[DIGIT-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
        bus.zi   = zi_reg;
        bus.co   = co_reg;
        bus.ov   = ov_reg;
    end

    // Subtraction reuses the adder as A + ~B + 1, so co reads as not-borrow.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            zi_reg  <= '0;
            co_reg  <= 1'b0;
            ov_reg  <= 1'b0;
        end else if (take) begin
            a_reg <= bus.xi;
            b_reg <= bus.sub ? ~bus.yi : bus.yi;
            carry <= bus.sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_reg   <= a_reg >> DIGIT;
            b_reg   <= b_reg >> DIGIT;
            carry   <= digit_sum[DIGIT];
            sum_reg <= sum_next;
            cnt     <= cnt + CW'(1);
            if (last_step) begin
                zi_reg <= sum_next;
                co_reg <= digit_sum[DIGIT];
                ov_reg <= msb_cin ^ digit_sum[DIGIT];
            end
        end
    end
endmodule

// File: tb/tb_sum_nb_seq.sv
// Bench for sum_nb_seq: a 4-bit/1-digit unit and an 8-bit/2-digit unit share clock and reset.
// Expected results come from hand-worked vectors and a plain arithmetic reference.
module tb_sum_nb_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    sum_nb_seq_if #(.WIDTH(4)) if4 ();
    sum_nb_seq_if #(.WIDTH(8)) if8 ();

    sum_nb_seq #(.WIDTH(4), .DIGIT(1)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    sum_nb_seq #(.WIDTH(8), .DIGIT(2)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one start, then counts clocks until done (bounded) and how many of them showed busy.
    task automatic applyStimulus(input bit wide, input logic [7:0] x, input logic [7:0] y,
                                 input logic s, output int lat, output int busy_cnt);
        @(negedge clk);
        if (wide) begin
            if8.start = 1'b1; if8.xi = x; if8.yi = y; if8.sub = s;
        end else begin
            if4.start = 1'b1; if4.xi = x[3:0]; if4.yi = y[3:0]; if4.sub = s;
        end
        @(posedge clk);
        @(negedge clk);
        if8.start = 1'b0;
        if4.start = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!(wide ? if8.done : if4.done) && lat < 20) begin
            if (wide ? if8.busy : if4.busy) busy_cnt++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic runCheck(input string tag, input bit wide, input logic [7:0] x, input logic [7:0] y,
                            input logic s, input logic [7:0] ez, input logic eco, input logic eov);
        int          lat;
        int          busy_cnt;
        logic [31:0] obs;
        applyStimulus(wide, x, y, s, lat, busy_cnt);
        obs = wide ? {22'd0, if8.zi, if8.co, if8.ov} : {22'd0, 4'd0, if4.zi, if4.co, if4.ov};
        checkOutput({tag, " result"}, obs, {22'd0, ez, eco, eov});
        checkOutput({tag, " latency"}, lat, 4);
        checkOutput({tag, " busy_cycles"}, busy_cnt, 4);
        checkOutput({tag, " busy_in_done"}, wide ? if8.busy : if4.busy, 0);
    endtask

    initial begin
        int          lat;
        int          dones;
        int          pulses;
        int          last_done;
        logic [4:0]  r;
        logic [3:0]  xa;
        logic [3:0]  ya;

        if4.start = 1'b0; if4.sub = 1'b0; if4.xi = '0; if4.yi = '0;
        if8.start = 1'b0; if8.sub = 1'b0; if8.xi = '0; if8.yi = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset4", {if4.busy, if4.done, if4.zi, if4.co, if4.ov}, 0);
        checkOutput("reset8", {if8.busy, if8.done, if8.zi, if8.co, if8.ov}, 0);
        rst = 1'b0;

        runCheck("add4 7+9", 0, 8'd7, 8'd9, 0, 8'd0, 1, 0);
        runCheck("add4 5+3", 0, 8'd5, 8'd3, 0, 8'd8, 0, 1);
        runCheck("sub4 3-5", 0, 8'd3, 8'd5, 1, 8'd14, 0, 0);
        runCheck("sub4 8-1", 0, 8'd8, 8'd1, 1, 8'd7, 1, 1);
        runCheck("sub4 6-6", 0, 8'd6, 8'd6, 1, 8'd0, 1, 0);
        runCheck("add8 200+100", 1, 8'd200, 8'd100, 0, 8'd44, 1, 0);
        runCheck("add8 127+1", 1, 8'd127, 8'd1, 0, 8'd128, 0, 1);
        runCheck("sub8 50-100", 1, 8'd50, 8'd100, 1, 8'd206, 0, 0);
        runCheck("sub8 128-1", 1, 8'd128, 8'd1, 1, 8'd127, 1, 1);
        runCheck("sub8 0-0", 1, 8'd0, 8'd0, 1, 8'd0, 1, 0);
        runCheck("add8 255+255", 1, 8'd255, 8'd255, 0, 8'd254, 1, 0);

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                xa = 4'(x);
                ya = 4'(y);
                r  = {1'b0, xa} + {1'b0, ya};
                runCheck($sformatf("exh4 %0d+%0d", x, y), 0, 8'(x), 8'(y), 0,
                         {4'd0, r[3:0]}, r[4], (xa[3] == ya[3]) && (r[3] != xa[3]));
            end
        end

        // A second start two cycles into RUN must neither restart nor queue.
        @(negedge clk);
        if4.start = 1'b1; if4.xi = 4'd3; if4.yi = 4'd2; if4.sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if4.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if4.start = 1'b1; if4.xi = 4'd9; if4.yi = 4'd9; if4.sub = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if4.start = 1'b0;
        lat = 2;
        while (!if4.done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput("ignore latency", lat, 4);
        checkOutput("ignore result", {if4.zi, if4.co, if4.ov}, {4'd5, 1'b0, 1'b0});
        dones = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (if4.done) dones++;
        end
        checkOutput("ignore no_second_done", dones, 0);

        // Reset during step 2 of 4 aborts the operation and clears the held result.
        @(negedge clk);
        if4.start = 1'b1; if4.xi = 4'd7; if4.yi = 4'd9; if4.sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if4.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst outputs", {if4.busy, if4.done, if4.zi, if4.co, if4.ov}, 0);
        dones = 0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (if4.done || if4.busy) dones++;
        end
        checkOutput("midrst quiet", dones, 0);
        runCheck("after_rst 5+3", 0, 8'd5, 8'd3, 0, 8'd8, 0, 1);

        // With start held high, a fresh operation begins every S+1 cycles.
        @(negedge clk);
        if4.start = 1'b1; if4.xi = 4'd1; if4.yi = 4'd1; if4.sub = 1'b0;
        pulses    = 0;
        last_done = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("b2b busy %0d", i), if4.busy, !if4.done);
            if (if4.done) begin
                pulses++;
                if (last_done >= 0) checkOutput($sformatf("b2b gap %0d", i), i - last_done, 5);
                last_done = i;
            end
        end
        checkOutput("b2b pulses", pulses, 6);
        checkOutput("b2b result", {if4.zi, if4.co, if4.ov}, {4'd2, 1'b0, 1'b0});
        if4.start = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sum_nb_seq.md
# sum_nb_seq

Parametrised sequential adder/subtractor, the multi-cycle successor to the 4-bit combinational adder. It accepts two WIDTH-bit operands on a start strobe, processes DIGIT bits per clock LSB-first through a DIGIT-bit ripple slice, and reports sum/difference, carry and signed overflow with a one-cycle done pulse. It sits between operand registers (switches or a controller FSM) and the display/result path, trading latency for a narrow adder slice.

## Interface

- WIDTH, 8, operand and result width in bits (≥2).
- DIGIT, 1, bits processed per clock; WIDTH must be an integer multiple of DIGIT. S = WIDTH/DIGIT is the step count.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  0 = xi+yi, 1 = xi−yi; sampled with start.
- xi  in  WIDTH  operand A, sampled with start.
- yi  in  WIDTH  operand B, sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a result is written.
- zi  out  WIDTH  result, held until the next completion.
- co  out  1  carry out (add) / not-borrow (sub).
- ov  out  1  two's-complement signed overflow.

## Operation

- States: IDLE, RUN, DONE. Reset → IDLE; zi=0, co=0, ov=0, busy=0, done=0, internal shift registers and step counter cleared.
- IDLE/DONE with start=1: latch A=xi, B=(sub ? ~yi : yi), carry=sub, counter=0 → RUN. start=0: DONE → IDLE, IDLE stays.
- RUN, each clock: add low DIGIT bits of A and B plus carry; shift result digit into an internal sum register from the MSB end; shift A, B right by DIGIT; update carry; counter++. On the step where counter reaches S−1 → DONE.
- Entering DONE: zi ← full sum register, co ← final carry, ov ← carry into MSB XOR carry out of MSB, done=1.
- start while in RUN is ignored (no restart, no queuing); xi/yi/sub changes during RUN do not affect the result.
- Result width rule: zi = (xi ± yi) mod 2^WIDTH. Add: co = 1 iff xi+yi ≥ 2^WIDTH. Sub: co = 1 iff xi ≥ yi unsigned. ov computed identically for both modes on the effective operands (A, ~B).
- rst=1 in any state, including mid-RUN: abort, return to IDLE, clear all outputs per reset values, no done pulse.
- rst and start in the same cycle: rst wins.

## Timing

- start sampled at edge k → busy=1 from edge k for exactly S cycles; state DONE, done=1, zi/co/ov valid from edge k+S; busy=0 in DONE.
- Latency start-edge to result: S clocks (WIDTH=4, DIGIT=1: 4; WIDTH=8, DIGIT=2: 4).
- done high for exactly one cycle unless start is asserted in DONE, in which case RUN begins at the next edge (back-to-back throughput one op per S+1 cycles); done still deasserts after one cycle.
- zi/co/ov change only on the edge that enters DONE or on reset.

## Test plan

- WIDTH=4, DIGIT=1: exhaustive xi,yi ∈ 0..15, sub=0 → each result at exactly 4 clocks after start, zi = (xi+yi) mod 16, co = carry; e.g. 7+9 → zi=0, co=1, ov=0; 5+3 → zi=8, co=0, ov=1.
- WIDTH=4, sub=1: 3−5 → zi=14, co=0, ov=0; 8−1 → zi=7, co=1, ov=1; 6−6 → zi=0, co=1, ov=0.
- WIDTH=8, DIGIT=2: 200+100 → done 4 clocks after start, zi=44, co=1; 127+1 → zi=128, ov=1, co=0.
- Start pulse at cycle 2 of a RUN with different operands → ignored; first op's result appears unchanged at its scheduled edge, no second done.
- rst asserted mid-RUN (step 2 of 4) → next cycle IDLE, busy=0, zi=0, co=0, ov=0, no done; following start runs normally.
- start held high continuously, WIDTH=4 → done pulses every 5 cycles, each pulse one cycle wide, busy low exactly in the DONE cycle.
